// File: rtl/bnn_pkg.sv
// -----------------------------------------------------------------------------
// bnn_pkg
// Shared definitions for the binarized second-layer classifier.
//   state_e   : FSM state encoding (IDLE=0, SCAN=1, DONE=2)
//   popcnt_w  : number of bits needed to hold a popcount of an n-bit vector
// -----------------------------------------------------------------------------
package bnn_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_e;

   // Width of a counter able to hold the values 0..n inclusive.
   function automatic int popcnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/bnn_popcount.sv
// -----------------------------------------------------------------------------
// bnn_popcount
// Purely combinational population count.
// Parameters:
//   WIDTH : width of the input vector
// Ports:
//   bits  : input  [WIDTH-1:0]            vector to count
//   count : output [popcnt_w(WIDTH)-1:0]  number of ones in bits
// -----------------------------------------------------------------------------
module bnn_popcount
   import bnn_pkg::*;
#(
   parameter int WIDTH = 4,
   localparam int CW = popcnt_w(WIDTH)
) (
   input  logic [WIDTH-1:0] bits,
   output logic [CW-1:0]    count
);

   always_comb begin
      count = '0;
      for (int i = 0; i < WIDTH; i++) begin
         count = count + CW'(bits[i]);
      end
   end

endmodule

// File: rtl/second_layer_rolin.sv
// -----------------------------------------------------------------------------
// second_layer_rolin
// Binarized output layer: scores the captured hidden vector against one binary
// weight row per class (XNOR + popcount), one class per cycle, and reports the
// index of the highest-scoring class (lowest index wins ties).
//
// Parameters:
//   HIDDEN_CNT : hidden-layer bits per inference
//   CLASS_CNT  : number of output classes (>= 2)
//   Weights    : row for class c at [c*HIDDEN_CNT +: HIDDEN_CNT], 1 = +1, 0 = -1
// Ports:
//   clk    : input                       clock, rising edge
//   rst    : input                       asynchronous reset, active low
//   start  : input                       hidden vector valid
//   hidden : input  [HIDDEN_CNT-1:0]     binarized hidden activations
//   klass  : output [$clog2(CLASS_CNT)]  winning class index
//   done   : output                      klass valid
//   score  : output [popcnt_w(HIDDEN_CNT)] winning popcount
//            (present only when SECOND_LAYER_SCORE_OUT_EN is defined)
//
// Optional feature macro: SECOND_LAYER_SCORE_OUT_EN
// -----------------------------------------------------------------------------
module second_layer_rolin
   import bnn_pkg::*;
#(
   parameter int                              HIDDEN_CNT = 4,
   parameter int                              CLASS_CNT  = 4,
   parameter logic [CLASS_CNT*HIDDEN_CNT-1:0] Weights    = '0,
   localparam int SCORE_W = popcnt_w(HIDDEN_CNT),
   localparam int CNT_W   = $clog2(CLASS_CNT)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [HIDDEN_CNT-1:0] hidden,
   output logic [CNT_W-1:0]      klass,
   output logic                  done
`ifdef SECOND_LAYER_SCORE_OUT_EN
   ,
   output logic [SCORE_W-1:0]    score
`endif
);

   state_e                 state_q, state_d;
   logic [HIDDEN_CNT-1:0]  hidden_q, hidden_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [SCORE_W-1:0]     max_q, max_d;
   logic [CNT_W-1:0]       idx_q, idx_d;
   logic [CNT_W-1:0]       klass_q, klass_d;
   logic                   done_q, done_d;
`ifdef SECOND_LAYER_SCORE_OUT_EN
   logic [SCORE_W-1:0]     score_q, score_d;
`endif

   logic [HIDDEN_CNT-1:0]  row;
   logic [HIDDEN_CNT-1:0]  match;
   logic [SCORE_W-1:0]     cur_score;
   logic                   cnt_last;
   logic                   take;

   // The counter never exceeds CLASS_CNT-1, so the slice stays inside Weights.
   assign row      = Weights[int'(cnt_q)*HIDDEN_CNT +: HIDDEN_CNT];
   assign match    = ~(hidden_q ^ row);
   assign cnt_last = (cnt_q == CNT_W'(CLASS_CNT - 1));
   // Class 0 always seeds the running max; later classes need a strict win,
   // which keeps the lower index on ties.
   assign take     = (cnt_q == '0) || (cur_score > max_q);

   bnn_popcount #(
      .WIDTH (HIDDEN_CNT)
   ) u_popcount (
      .bits  (match),
      .count (cur_score)
   );

   // State register and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         hidden_q <= '0;
         cnt_q    <= '0;
         max_q    <= '0;
         idx_q    <= '0;
         klass_q  <= '0;
         done_q   <= 1'b0;
`ifdef SECOND_LAYER_SCORE_OUT_EN
         score_q  <= '0;
`endif
      end else begin
         state_q  <= state_d;
         hidden_q <= hidden_d;
         cnt_q    <= cnt_d;
         max_q    <= max_d;
         idx_q    <= idx_d;
         klass_q  <= klass_d;
         done_q   <= done_d;
`ifdef SECOND_LAYER_SCORE_OUT_EN
         score_q  <= score_d;
`endif
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = SCAN;
         SCAN:    if (cnt_last) state_d = DONE;
         // The first DONE cycle always publishes the result; after that the
         // result is held until start is seen low.
         DONE:    if (done_q && !start) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output / datapath logic
   always_comb begin
      hidden_d = hidden_q;
      cnt_d    = cnt_q;
      max_d    = max_q;
      idx_d    = idx_q;
      klass_d  = klass_q;
      done_d   = done_q;
`ifdef SECOND_LAYER_SCORE_OUT_EN
      score_d  = score_q;
`endif
      unique case (state_q)
         IDLE: begin
            done_d = 1'b0;
            if (start) begin
               hidden_d = hidden;
               cnt_d    = '0;
               max_d    = '0;
               idx_d    = '0;
            end
         end
         SCAN: begin
            if (take) begin
               max_d = cur_score;
               idx_d = cnt_q;
            end
            if (!cnt_last) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            if (!done_q) begin
               done_d  = 1'b1;
               klass_d = idx_q;
`ifdef SECOND_LAYER_SCORE_OUT_EN
               score_d = max_q;
`endif
            end else if (!start) begin
               done_d = 1'b0;
            end
         end
         default: done_d = 1'b0;
      endcase
   end

   assign klass = klass_q;
   assign done  = done_q;
`ifdef SECOND_LAYER_SCORE_OUT_EN
   assign score = score_q;
`endif

endmodule

// File: tb/tb_second_layer_rolin.sv
// -----------------------------------------------------------------------------
// tb_second_layer_rolin
// Self-checking bench for second_layer_rolin with HIDDEN_CNT=4, CLASS_CNT=4 and
// rows c0=0000, c1=1111, c2=1010, c3=0101. Expected results come from a
// behavioural scoring model (bit-match counting, first strict maximum).
// -----------------------------------------------------------------------------
module tb_second_layer_rolin;

   localparam int          H_CNT  = 4;
   localparam int          C_CNT  = 4;
   localparam logic [15:0] W_ROWS = 16'h5AF0;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] hidden;
   logic [1:0] klass;
   logic       done;
`ifdef SECOND_LAYER_SCORE_OUT_EN
   logic [2:0] score;
`endif

   int n_tests;
   int n_fail;
   logic [15:0] w_rows;

   second_layer_rolin #(
      .HIDDEN_CNT (H_CNT),
      .CLASS_CNT  (C_CNT),
      .Weights    (W_ROWS)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .hidden (hidden),
      .klass  (klass),
      .done   (done)
`ifdef SECOND_LAYER_SCORE_OUT_EN
      ,
      .score  (score)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Score every class by counting agreeing bits; keep the first strict maximum.
   task automatic model(input logic [3:0] h, output int best_c, output int best_s);
      best_c = 0;
      best_s = -1;
      for (int c = 0; c < C_CNT; c++) begin
         int s;
         s = 0;
         for (int b = 0; b < H_CNT; b++) begin
            if (h[b] == w_rows[c*H_CNT + b]) s++;
         end
         if (s > best_s) begin
            best_s = s;
            best_c = c;
         end
      end
   endtask

   task automatic run_inf(input logic [3:0] h, input bit wiggle, input string tag);
      int exp_c, exp_s, early;
      model(h, exp_c, exp_s);
      @(negedge clk);
      hidden = h;
      start  = 1'b1;
      @(posedge clk);
      #1;
      early = 0;
      for (int k = 1; k <= 5; k++) begin
         if (wiggle && k < 5) begin
            hidden = 4'($urandom);
            start  = (k < 4) ? 1'($urandom) : 1'b1;
         end
         @(posedge clk);
         #1;
         if (k < 5 && done) early++;
      end
      check({tag, " early_done"}, early, 0);
      check({tag, " done"}, done, 1);
      check({tag, " klass"}, klass, exp_c);
`ifdef SECOND_LAYER_SCORE_OUT_EN
      check({tag, " score"}, score, exp_s);
`endif
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         #1;
         check({tag, " hold_done"}, done, 1);
         check({tag, " hold_klass"}, klass, exp_c);
      end
      start = 1'b0;
      @(posedge clk);
      #1;
      check({tag, " drop_done"}, done, 0);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      w_rows  = W_ROWS;
      rst     = 1'b0;
      start   = 1'b0;
      hidden  = 4'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset done", done, 0);
      check("reset klass", klass, 0);
      @(negedge clk);
      rst = 1'b1;

      run_inf(4'b1111, 1'b0, "h1111");
      run_inf(4'b0000, 1'b0, "h0000");
      run_inf(4'b1100, 1'b0, "tie1100");
      run_inf(4'b0101, 1'b0, "repulse0101");
      run_inf(4'b1010, 1'b1, "wiggle1010");
      run_inf(4'b0101, 1'b0, "pre_reset0101");

      // Abort an inference two cycles into the scan.
      @(negedge clk);
      hidden = 4'b1010;
      start  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst   = 1'b0;
      start = 1'b0;
      #1;
      check("abort done", done, 0);
      check("abort klass", klass, 0);
      @(posedge clk);
      #1;
      check("abort hold done", done, 0);
      @(negedge clk);
      rst = 1'b1;
      run_inf(4'b1111, 1'b0, "post_reset1111");

      for (int i = 0; i < 20; i++) begin
         run_inf(4'($urandom), 1'($urandom), $sformatf("rand%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
